// File: rtl/ds_mem_reader.sv
// ds_mem_reader
// Read-side consumer of the DS segment register. A byte or word read request
// carries a 16-bit offset; the block forms the 20-bit physical address
// (DS<<4)+offset, performs one or two byte reads on an 8-bit handshake bus,
// and returns the little-endian assembled data on a valid/ready response port.
// Each byte read is bounded by a timeout that aborts the access with rsp_err.
module ds_mem_reader #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] ds_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_offset,
    input  logic        req_word,
    output logic        mem_rd,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD_LO = 2'd1;
    localparam logic [1:0] ST_RD_HI = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Value the counter holds during the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Real-mode style segment:offset translation, wrapping at 1 MiB.
    function automatic logic [19:0] phys_addr(input logic [15:0] seg,
                                              input logic [15:0] off);
        phys_addr = {seg, 4'h0} + {4'h0, off};
    endfunction

    logic [1:0]       state_r;
    logic [15:0]      ds_r;
    logic [15:0]      off_r;
    logic             word_r;
    logic [CNT_W-1:0] cnt_r;
    logic             req_ready_r;
    logic             mem_rd_r;
    logic [19:0]      mem_addr_r;
    logic             rsp_valid_r;
    logic [15:0]      rsp_data_r;
    logic             rsp_err_r;

    logic [19:0]      accept_addr_s;
    logic [15:0]      hi_off_s;
    logic [19:0]      hi_addr_s;
    logic             ack_s;
    logic             expire_s;

    // Address forms and per-cycle read outcome (ack only counts while strobing).
    always_comb begin
        accept_addr_s = phys_addr(ds_i, req_offset);
        hi_off_s      = off_r + 16'd1;
        hi_addr_s     = phys_addr(ds_r, hi_off_s);
        ack_s         = mem_rd_r & mem_ack;
        expire_s      = mem_rd_r & ~mem_ack & (cnt_r == CNT_LAST);
    end

    // Main FSM: request snapshot, byte reads with timeout, response hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            ds_r        <= 16'h0000;
            off_r       <= 16'h0000;
            word_r      <= 1'b0;
            cnt_r       <= CNT_ZERO;
            req_ready_r <= 1'b1;
            mem_rd_r    <= 1'b0;
            mem_addr_r  <= 20'h00000;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 16'h0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        // Snapshot so later DS/offset changes cannot disturb the access.
                        ds_r        <= ds_i;
                        off_r       <= req_offset;
                        word_r      <= req_word;
                        req_ready_r <= 1'b0;
                        mem_rd_r    <= 1'b1;
                        mem_addr_r  <= accept_addr_s;
                        cnt_r       <= CNT_ZERO;
                        rsp_data_r  <= 16'h0000;
                        rsp_err_r   <= 1'b0;
                        state_r     <= ST_RD_LO;
                    end else begin
                        // Coming back from RESP, ready rises one cycle after the handshake.
                        req_ready_r <= 1'b1;
                    end
                end
                ST_RD_LO: begin
                    if (ack_s) begin
                        rsp_data_r[7:0] <= mem_rdata;
                        mem_rd_r        <= 1'b0;
                        if (word_r) begin
                            // One idle strobe cycle before the high byte read.
                            mem_addr_r <= hi_addr_s;
                            cnt_r      <= CNT_ZERO;
                            state_r    <= ST_RD_HI;
                        end else begin
                            rsp_data_r[15:8] <= 8'h00;
                            rsp_valid_r      <= 1'b1;
                            state_r          <= ST_RESP;
                        end
                    end else if (expire_s) begin
                        mem_rd_r    <= 1'b0;
                        rsp_data_r  <= 16'h0000;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else if (mem_rd_r) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        mem_rd_r <= 1'b1;
                    end
                end
                ST_RD_HI: begin
                    if (!mem_rd_r) begin
                        mem_rd_r <= 1'b1;
                    end else if (ack_s) begin
                        rsp_data_r[15:8] <= mem_rdata;
                        mem_rd_r         <= 1'b0;
                        rsp_valid_r      <= 1'b1;
                        state_r          <= ST_RESP;
                    end else if (expire_s) begin
                        mem_rd_r    <= 1'b0;
                        rsp_data_r  <= 16'h0000;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    mem_rd_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign mem_rd    = mem_rd_r;
    assign mem_addr  = mem_addr_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ds_mem_reader.sv
// Scoreboard bench for ds_mem_reader: requests push expected bus addresses and
// responses; a memory responder and a response monitor pop and compare them.
module tb_ds_mem_reader;

    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic        CLK;
    logic        RST;
    logic [15:0] ds_i;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_offset;
    logic        req_word;
    logic        mem_rd;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    ds_mem_reader #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .ds_i(ds_i),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_offset(req_offset), .req_word(req_word),
        .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    typedef struct { logic [19:0] addr; int lat; } rd_t;
    typedef struct { logic [15:0] data; logic err; } rsp_t;

    rd_t         rd_q[$];
    rsp_t        sb_q[$];
    logic [7:0]  mem [logic [19:0]];
    int          checks = 0;
    int          errors = 0;
    int          run = 0;
    int          last_run = 0;
    int          cur_lat = NEVER;
    logic [19:0] cur_addr = 20'h0;
    logic        force_ack = 1'b0;
    logic        held = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic        prev_err = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] memrd(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    // Independent address model: linear segment*16 + offset, modulo 1 MiB.
    function automatic logic [19:0] lin(input logic [15:0] seg, input logic [15:0] off);
        int unsigned v;
        v = (32'(seg) * 32'd16 + 32'(off)) % 32'h100000;
        return v[19:0];
    endfunction

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory responder: checks address per strobe, acks after the queued latency.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge CLK);
            mem_ack = force_ack;
            mem_rdata = 8'h00;
            if (RST) begin
                run = 0;
            end else if (mem_rd) begin
                if (run == 0) begin
                    if (rd_q.size() == 0) begin
                        check_val("rd_unexpected", 32'(1), 32'(0));
                        cur_lat = NEVER;
                        cur_addr = mem_addr;
                    end else begin
                        rd_t e;
                        e = rd_q.pop_front();
                        cur_lat = e.lat;
                        cur_addr = e.addr;
                        check_val("mem_addr", 32'(mem_addr), 32'(e.addr));
                    end
                end else begin
                    check_val("mem_addr_hold", 32'(mem_addr), 32'(cur_addr));
                end
                if (run == cur_lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = memrd(mem_addr);
                end
                run++;
            end else begin
                if (run != 0) last_run = run;
                run = 0;
            end
        end
    end

    // Response monitor: stability under backpressure and scoreboard compare.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && rsp_valid) begin
                check_val("rd_in_resp", 32'(mem_rd), 32'(0));
                if (held) begin
                    check_val("rsp_data_hold", 32'(rsp_data), 32'(prev_data));
                    check_val("rsp_err_hold", 32'(rsp_err), 32'(prev_err));
                end
                if (rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        check_val("rsp_unexpected", 32'(1), 32'(0));
                    end else begin
                        rsp_t e;
                        e = sb_q.pop_front();
                        check_val("rsp_data", 32'(rsp_data), 32'(e.data));
                        check_val("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prev_data = rsp_data;
                    prev_err = rsp_err;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic do_req(input logic [15:0] ds, input logic [15:0] off, input logic word,
                          input int lat_lo, input int lat_hi, input logic push_rsp);
        int n;
        logic [19:0] lo;
        logic [19:0] hi;
        rsp_t r;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        check_val("req_ready_wait", 32'(req_ready), 32'(1));
        lo = lin(ds, off);
        hi = lin(ds, 16'((32'(off) + 32'd1) % 32'h10000));
        rd_q.push_back('{addr: lo, lat: lat_lo});
        if (lat_lo >= TO) begin
            r = '{data: 16'h0000, err: 1'b1};
        end else if (word) begin
            rd_q.push_back('{addr: hi, lat: lat_hi});
            if (lat_hi >= TO) r = '{data: 16'h0000, err: 1'b1};
            else r = '{data: {memrd(hi), memrd(lo)}, err: 1'b0};
        end else begin
            r = '{data: {8'h00, memrd(lo)}, err: 1'b0};
        end
        if (push_rsp) sb_q.push_back(r);
        ds_i = ds;
        req_offset = off;
        req_word = word;
        req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check_val("rsp_timeout", 32'(sb_q.size()), 32'(0));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check_val("valid_wait", 32'(rsp_valid), 32'(1));
    endtask

    initial begin
        RST = 1'b1;
        ds_i = 16'h0;
        req_valid = 1'b0;
        req_offset = 16'h0;
        req_word = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_req_ready", 32'(req_ready), 32'(1));
        check_val("rst_mem_rd", 32'(mem_rd), 32'(0));
        check_val("rst_mem_addr", 32'(mem_addr), 32'(0));
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check_val("rst_rsp_data", 32'(rsp_data), 32'(0));
        check_val("rst_rsp_err", 32'(rsp_err), 32'(0));
        RST = 1'b0;
        @(posedge CLK); #1;

        // Byte read, ack one cycle after strobe; response timing and ready return.
        mem[20'h12350] = 8'hA5;
        do_req(16'h1234, 16'h0010, 1'b0, 1, 0, 1'b1);
        @(posedge CLK); #1;
        check_val("t1_valid_c1", 32'(rsp_valid), 32'(0));
        @(posedge CLK); #1;
        check_val("t1_valid_c2", 32'(rsp_valid), 32'(1));
        @(posedge CLK); #1;
        check_val("t1_valid_drop", 32'(rsp_valid), 32'(0));
        check_val("t1_ready_low", 32'(req_ready), 32'(0));
        @(posedge CLK); #1;
        check_val("t1_ready_rise", 32'(req_ready), 32'(1));
        wait_rsp();

        // Word read with in-segment offset wrap, zero-wait acks; 6-cycle spacing.
        mem[20'hFFFFF] = 8'h34;
        mem[20'hF0000] = 8'h12;
        do_req(16'hF000, 16'hFFFF, 1'b1, 0, 0, 1'b1);
        repeat (4) @(posedge CLK);
        #1;
        check_val("t2_ready_low", 32'(req_ready), 32'(0));
        @(posedge CLK); #1;
        check_val("t2_ready_rise", 32'(req_ready), 32'(1));
        wait_rsp();

        // Physical wrap at 1 MiB.
        mem[20'h00010] = 8'h3C;
        do_req(16'hFFFF, 16'h0020, 1'b0, 2, 0, 1'b1);
        wait_rsp();

        // Ack on the last permitted cycle wins over the timeout.
        do_req(16'h0100, 16'h0004, 1'b0, TO - 1, 0, 1'b1);
        wait_rsp();

        // Timeout on the low byte, held response ignores a late ack.
        rsp_ready = 1'b0;
        do_req(16'h4000, 16'h0000, 1'b0, NEVER, 0, 1'b1);
        wait_valid();
        @(posedge CLK); #1;
        check_val("t4_strobe_len", 32'(last_run), 32'(TO));
        force_ack = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_val("t4_valid", 32'(rsp_valid), 32'(1));
        check_val("t4_err", 32'(rsp_err), 32'(1));
        check_val("t4_data", 32'(rsp_data), 32'(0));
        check_val("t4_mem_rd", 32'(mem_rd), 32'(0));
        force_ack = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp();

        // Timeout on the high byte of a word read.
        do_req(16'h0200, 16'h0010, 1'b1, 0, NEVER, 1'b1);
        wait_rsp();

        // Backpressure and DS snapshot.
        rsp_ready = 1'b0;
        mem[20'h20100] = 8'hCD;
        mem[20'h20101] = 8'hAB;
        do_req(16'h2000, 16'h0100, 1'b1, 1, 1, 1'b1);
        ds_i = 16'hBEEF;
        check_val("t5_ready_busy", 32'(req_ready), 32'(0));
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check_val("t5_ready_hold", 32'(req_ready), 32'(0));
            check_val("t5_valid_hold", 32'(rsp_valid), 32'(1));
        end
        rsp_ready = 1'b1;
        wait_rsp();

        // Reset while the high byte read is waiting.
        do_req(16'h3000, 16'h0040, 1'b1, 0, NEVER, 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check_val("t6_in_hi", 32'(mem_rd), 32'(1));
        #2;
        RST = 1'b1;
        #1;
        check_val("t6_rst_mem_rd", 32'(mem_rd), 32'(0));
        check_val("t6_rst_valid", 32'(rsp_valid), 32'(0));
        check_val("t6_rst_ready", 32'(req_ready), 32'(1));
        rd_q.delete();
        sb_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        mem[20'h00012] = 8'h77;
        do_req(16'h0001, 16'h0002, 1'b0, 0, 0, 1'b1);
        wait_rsp();

        repeat (3) @(posedge CLK);
        #1;
        check_val("sb_empty", 32'(sb_q.size()), 32'(0));
        check_val("rd_q_empty", 32'(rd_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
